periph_ctrl: RTL and testbench

PERIPH_CTRL -- requirements
Module: periph_ctrl

---
 rtl/periph_ctrl.sv | 160 ++++++++++++++++
 tb/tb_periph_ctrl.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/periph_ctrl.sv
// Memory-mapped peripheral block: LED register, debounced switch input and a
// 32-bit compare timer, with a level-sensitive interrupt combining both sources.
module periph_ctrl #(
  parameter logic [31:0] BASE     = 32'hFFFF_FF00,
  parameter int          DEBOUNCE = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] DataAdr,
  input  logic [31:0] WriteData,
  input  logic        MemWrite,
  input  logic [9:0]  switches,
  output logic [31:0] ReadData,
  output logic        sel,
  output logic [9:0]  leds,
  output logic        irq
);

  localparam logic [5:0] R_LED  = 6'h00;
  localparam logic [5:0] R_SW   = 6'h01;
  localparam logic [5:0] R_CNT  = 6'h02;
  localparam logic [5:0] R_CMP  = 6'h03;
  localparam logic [5:0] R_CTRL = 6'h04;
  localparam logic [5:0] R_STAT = 6'h05;

  typedef enum logic {DB_STABLE, DB_CHANGING} db_state_t;

  logic [5:0]  widx;
  logic        we;
  logic        unused_adr;

  logic [9:0]  led_q;
  logic [31:0] cnt_q, cmp_q;
  logic [3:0]  ctrl_q;
  logic [1:0]  stat_q;

  logic [9:0]  sync1_q, sync2_q, sw_q;
  logic [7:0]  dcnt_q, dcnt_next;
  db_state_t   db_state, db_next;
  logic        sw_load, swchg_set;

  logic        match;
  logic [31:0] cnt_next;
  logic [3:0]  ctrl_next;
  logic [1:0]  stat_next;

  // Byte offset within the word is irrelevant to this register map
  assign unused_adr = ^DataAdr[1:0];
  assign widx       = DataAdr[7:2];
  assign sel        = (DataAdr[31:8] == BASE[31:8]);
  assign we         = MemWrite & sel;
  assign leds       = led_q;
  assign irq        = (stat_q[0] & ctrl_q[2]) | (stat_q[1] & ctrl_q[3]);

  always_ff @(posedge clk) begin
    if (reset) begin
      sync1_q <= '0;
      sync2_q <= '0;
    end else begin
      sync1_q <= switches;
      sync2_q <= sync1_q;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) db_state <= DB_STABLE;
    else       db_state <= db_next;
  end

  always_comb begin
    db_next = db_state;
    case (db_state)
      DB_STABLE:   if (sync2_q != sw_q) db_next = DB_CHANGING;
      DB_CHANGING: if ((sync2_q == sw_q) || (dcnt_q == 8'(DEBOUNCE))) db_next = DB_STABLE;
      default:     db_next = DB_STABLE;
    endcase
  end

  // A new pattern mid-change keeps counting; SW takes whatever is synced at acceptance
  always_comb begin
    dcnt_next = dcnt_q;
    sw_load   = 1'b0;
    swchg_set = 1'b0;
    case (db_state)
      DB_STABLE: if (sync2_q != sw_q) dcnt_next = 8'd1;
      DB_CHANGING: begin
        if (sync2_q == sw_q) begin
          dcnt_next = 8'd0;
        end else if (dcnt_q == 8'(DEBOUNCE)) begin
          dcnt_next = 8'd0;
          sw_load   = 1'b1;
          swchg_set = 1'b1;
        end else begin
          dcnt_next = dcnt_q + 8'd1;
        end
      end
      default: dcnt_next = 8'd0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      dcnt_q <= '0;
      sw_q   <= '0;
    end else begin
      dcnt_q <= dcnt_next;
      if (sw_load) sw_q <= sync2_q;
    end
  end

  // Timer: match uses the pre-write count; software writes override hardware updates,
  // except that a hardware status set wins over a same-cycle W1C
  always_comb begin
    match     = ctrl_q[0] && (cnt_q == cmp_q);
    cnt_next  = cnt_q;
    ctrl_next = ctrl_q;
    if (ctrl_q[0]) begin
      if (match) cnt_next = ctrl_q[1] ? 32'd0 : cnt_q;
      else       cnt_next = cnt_q + 32'd1;
    end
    if (match && !ctrl_q[1]) ctrl_next[0] = 1'b0;
    if (we && widx == R_CNT)  cnt_next  = WriteData;
    if (we && widx == R_CTRL) ctrl_next = WriteData[3:0];
    stat_next = stat_q;
    if (we && widx == R_STAT) stat_next = stat_q & ~WriteData[1:0];
    stat_next = stat_next | {swchg_set, match};
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      led_q  <= '0;
      cnt_q  <= '0;
      cmp_q  <= 32'hFFFF_FFFF;
      ctrl_q <= '0;
      stat_q <= '0;
    end else begin
      if (we && widx == R_LED) led_q <= WriteData[9:0];
      if (we && widx == R_CMP) cmp_q <= WriteData;
      cnt_q  <= cnt_next;
      ctrl_q <= ctrl_next;
      stat_q <= stat_next;
    end
  end

  always_comb begin
    ReadData = '0;
    if (sel) begin
      case (widx)
        R_LED:   ReadData = {22'd0, led_q};
        R_SW:    ReadData = {22'd0, sw_q};
        R_CNT:   ReadData = cnt_q;
        R_CMP:   ReadData = cmp_q;
        R_CTRL:  ReadData = {28'd0, ctrl_q};
        R_STAT:  ReadData = {30'd0, stat_q};
        default: ReadData = '0;
      endcase
    end
  end

endmodule

// File: tb/tb_periph_ctrl.sv
// Directed bench for periph_ctrl: register access, switch debounce, timer modes,
// status W1C collision and reset abandonment.
module tb_periph_ctrl;

  localparam logic [31:0] B = 32'hFFFF_FF00;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] DataAdr, WriteData, ReadData;
  logic        MemWrite, sel, irq;
  logic [9:0]  switches, leds;

  int ncmp = 0;
  int nbad = 0;

  periph_ctrl #(.BASE(B), .DEBOUNCE(4)) dut (
    .clk(clk), .reset(reset), .DataAdr(DataAdr), .WriteData(WriteData),
    .MemWrite(MemWrite), .switches(switches), .ReadData(ReadData),
    .sel(sel), .leds(leds), .irq(irq)
  );

  always #5 clk = ~clk;

  // Called at a falling edge; the write lands on the next rising edge
  task automatic wr(input logic [31:0] adr, input logic [31:0] data);
    DataAdr = adr; WriteData = data; MemWrite = 1'b1;
    @(negedge clk);
    MemWrite = 1'b0;
  endtask

  task automatic rd(input logic [31:0] adr, output logic [31:0] d);
    DataAdr = adr;
    #1;
    d = ReadData;
  endtask

  task automatic test_reset();
    logic [31:0] d;
    reset = 1'b1; MemWrite = 1'b0; DataAdr = '0; WriteData = '0; switches = '0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    ncmp++; if (leds !== 10'd0) begin nbad++; $display("FAIL rst_leds got %h want 000", leds); end
    ncmp++; if (irq !== 1'b0) begin nbad++; $display("FAIL rst_irq got %b want 0", irq); end
    rd(B + 32'h08, d); ncmp++; if (d !== 32'd0) begin nbad++; $display("FAIL rst_cnt got %h want 0", d); end
    rd(B + 32'h0C, d); ncmp++; if (d !== 32'hFFFF_FFFF) begin nbad++; $display("FAIL rst_cmp got %h want ffffffff", d); end
    rd(B + 32'h10, d); ncmp++; if (d !== 32'd0) begin nbad++; $display("FAIL rst_ctrl got %h want 0", d); end
    rd(B + 32'h14, d); ncmp++; if (d !== 32'd0) begin nbad++; $display("FAIL rst_stat got %h want 0", d); end
    rd(B + 32'h04, d); ncmp++; if (d !== 32'd0) begin nbad++; $display("FAIL rst_sw got %h want 0", d); end
    @(negedge clk);
  endtask

  task automatic test_led();
    logic [31:0] d;
    wr(B + 32'h00, 32'h2A5);
    ncmp++; if (leds !== 10'h2A5) begin nbad++; $display("FAIL led_port got %h want 2a5", leds); end
    rd(B + 32'h00, d); ncmp++; if (d !== 32'h2A5) begin nbad++; $display("FAIL led_read got %h want 2a5", d); end
    rd(B + 32'h02, d); ncmp++; if (d !== 32'h2A5) begin nbad++; $display("FAIL led_read_unaligned got %h want 2a5", d); end
    rd(B + 32'h40, d); ncmp++; if (d !== 32'd0) begin nbad++; $display("FAIL unmapped_read got %h want 0", d); end
    rd(32'h0000_0000, d);
    ncmp++; if (sel !== 1'b0 || d !== 32'd0) begin nbad++; $display("FAIL nosel_read got sel=%b %h want sel=0 0", sel, d); end
    ncmp++; if (sel !== 1'b0) begin nbad++; $display("FAIL sel_low got %b want 0", sel); end
    wr(32'h0000_0000, 32'h155);
    ncmp++; if (leds !== 10'h2A5) begin nbad++; $display("FAIL nosel_write got %h want 2a5", leds); end
    wr(B + 32'h04, 32'h3FF);
    rd(B + 32'h04, d); ncmp++; if (d !== 32'd0) begin nbad++; $display("FAIL ro_sw_write got %h want 0", d); end
    wr(B + 32'h00, 32'hFFFF_FFFF);
    rd(B + 32'h00, d); ncmp++; if (d !== 32'h3FF) begin nbad++; $display("FAIL led_width got %h want 3ff", d); end
    wr(B + 32'h00, 32'h2A5);
  endtask

  task automatic test_switch();
    logic [31:0] d;
    switches = 10'h3FF;
    repeat (3) @(negedge clk);
    switches = 10'h000;
    repeat (10) @(negedge clk);
    rd(B + 32'h04, d); ncmp++; if (d !== 32'd0) begin nbad++; $display("FAIL sw_pulse got %h want 0", d); end
    rd(B + 32'h14, d); ncmp++; if (d !== 32'd0) begin nbad++; $display("FAIL sw_pulse_stat got %h want 0", d); end
    switches = 10'h3FF;
    repeat (6) @(negedge clk);
    rd(B + 32'h04, d); ncmp++; if (d !== 32'd0) begin nbad++; $display("FAIL sw_early got %h want 0", d); end
    @(negedge clk);
    rd(B + 32'h04, d); ncmp++; if (d !== 32'h3FF) begin nbad++; $display("FAIL sw_accept got %h want 3ff", d); end
    rd(B + 32'h14, d); ncmp++; if (d !== 32'h2) begin nbad++; $display("FAIL sw_swchg got %h want 2", d); end
    ncmp++; if (irq !== 1'b0) begin nbad++; $display("FAIL sw_irq_masked got %b want 0", irq); end
    wr(B + 32'h10, 32'h8);
    ncmp++; if (irq !== 1'b1) begin nbad++; $display("FAIL sw_irq got %b want 1", irq); end
    wr(B + 32'h14, 32'h2);
    ncmp++; if (irq !== 1'b0) begin nbad++; $display("FAIL sw_irq_clr got %b want 0", irq); end
    wr(B + 32'h10, 32'h0);
    switches = 10'h0F0;
    repeat (2) @(negedge clk);
    switches = 10'h00F;
    repeat (4) @(negedge clk);
    rd(B + 32'h04, d); ncmp++; if (d !== 32'h3FF) begin nbad++; $display("FAIL sw_mid_early got %h want 3ff", d); end
    @(negedge clk);
    rd(B + 32'h04, d); ncmp++; if (d !== 32'h00F) begin nbad++; $display("FAIL sw_mid_accept got %h want 00f", d); end
    wr(B + 32'h14, 32'h2);
  endtask

  task automatic test_timer_auto();
    logic [31:0] d;
    wr(B + 32'h0C, 32'd5);
    wr(B + 32'h10, 32'h7);
    rd(B + 32'h08, d); ncmp++; if (d !== 32'd0) begin nbad++; $display("FAIL auto_start got %h want 0", d); end
    repeat (5) @(negedge clk);
    rd(B + 32'h08, d); ncmp++; if (d !== 32'd5) begin nbad++; $display("FAIL auto_cnt5 got %h want 5", d); end
    ncmp++; if (irq !== 1'b0) begin nbad++; $display("FAIL auto_irq_early got %b want 0", irq); end
    @(negedge clk);
    rd(B + 32'h08, d); ncmp++; if (d !== 32'd0) begin nbad++; $display("FAIL auto_reload got %h want 0", d); end
    rd(B + 32'h14, d); ncmp++; if (d !== 32'h1) begin nbad++; $display("FAIL auto_match got %h want 1", d); end
    ncmp++; if (irq !== 1'b1) begin nbad++; $display("FAIL auto_irq got %b want 1", irq); end
    @(negedge clk);
    rd(B + 32'h08, d); ncmp++; if (d !== 32'd1) begin nbad++; $display("FAIL auto_cnt1 got %h want 1", d); end
    wr(B + 32'h14, 32'h1);
    rd(B + 32'h14, d); ncmp++; if (d !== 32'h0) begin nbad++; $display("FAIL auto_w1c got %h want 0", d); end
    ncmp++; if (irq !== 1'b0) begin nbad++; $display("FAIL auto_irq_clr got %b want 0", irq); end
    wr(B + 32'h10, 32'h0);
  endtask

  task automatic test_oneshot();
    logic [31:0] d;
    wr(B + 32'h08, 32'd0);
    wr(B + 32'h0C, 32'd3);
    wr(B + 32'h10, 32'h1);
    repeat (10) @(negedge clk);
    rd(B + 32'h08, d); ncmp++; if (d !== 32'd3) begin nbad++; $display("FAIL oneshot_cnt got %h want 3", d); end
    rd(B + 32'h10, d); ncmp++; if (d !== 32'd0) begin nbad++; $display("FAIL oneshot_ctrl got %h want 0", d); end
    rd(B + 32'h14, d); ncmp++; if (d !== 32'h1) begin nbad++; $display("FAIL oneshot_match got %h want 1", d); end
    ncmp++; if (irq !== 1'b0) begin nbad++; $display("FAIL oneshot_irq got %b want 0", irq); end
    wr(B + 32'h14, 32'h1);
  endtask

  task automatic test_wrap();
    logic [31:0] d;
    wr(B + 32'h08, 32'hFFFF_FFFE);
    wr(B + 32'h0C, 32'd5);
    wr(B + 32'h10, 32'h1);
    repeat (2) @(negedge clk);
    rd(B + 32'h08, d); ncmp++; if (d !== 32'd0) begin nbad++; $display("FAIL wrap_cnt got %h want 0", d); end
    rd(B + 32'h14, d); ncmp++; if (d !== 32'd0) begin nbad++; $display("FAIL wrap_noflag got %h want 0", d); end
    repeat (6) @(negedge clk);
    rd(B + 32'h08, d); ncmp++; if (d !== 32'd5) begin nbad++; $display("FAIL wrap_cnt5 got %h want 5", d); end
    rd(B + 32'h14, d); ncmp++; if (d !== 32'h1) begin nbad++; $display("FAIL wrap_match got %h want 1", d); end
    wr(B + 32'h14, 32'h1);
  endtask

  task automatic test_collision();
    logic [31:0] d;
    wr(B + 32'h08, 32'd0);
    wr(B + 32'h0C, 32'd5);
    wr(B + 32'h10, 32'h3);
    repeat (5) @(negedge clk);
    rd(B + 32'h08, d); ncmp++; if (d !== 32'd5) begin nbad++; $display("FAIL coll_cnt5 got %h want 5", d); end
    wr(B + 32'h14, 32'h1);
    rd(B + 32'h14, d); ncmp++; if (d !== 32'h1) begin nbad++; $display("FAIL coll_hw_wins got %h want 1", d); end
    wr(B + 32'h14, 32'h1);
    rd(B + 32'h14, d); ncmp++; if (d !== 32'h0) begin nbad++; $display("FAIL coll_w1c got %h want 0", d); end
    rd(B + 32'h08, d); ncmp++; if (d !== 32'd1) begin nbad++; $display("FAIL coll_cnt1 got %h want 1", d); end
    repeat (4) @(negedge clk);
    wr(B + 32'h08, 32'd100);
    rd(B + 32'h08, d); ncmp++; if (d !== 32'd100) begin nbad++; $display("FAIL cntwr_override got %h want 100", d); end
    rd(B + 32'h14, d); ncmp++; if (d !== 32'h1) begin nbad++; $display("FAIL cntwr_match got %h want 1", d); end
  endtask

  task automatic test_reset_midcount();
    logic [31:0] d;
    wr(B + 32'h10, 32'h5);
    ncmp++; if (irq !== 1'b1) begin nbad++; $display("FAIL pre_rst_irq got %b want 1", irq); end
    switches = 10'h3FF;
    repeat (4) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    ncmp++; if (irq !== 1'b0) begin nbad++; $display("FAIL mid_rst_irq got %b want 0", irq); end
    ncmp++; if (leds !== 10'd0) begin nbad++; $display("FAIL mid_rst_leds got %h want 0", leds); end
    rd(B + 32'h08, d); ncmp++; if (d !== 32'd0) begin nbad++; $display("FAIL mid_rst_cnt got %h want 0", d); end
    rd(B + 32'h10, d); ncmp++; if (d !== 32'd0) begin nbad++; $display("FAIL mid_rst_ctrl got %h want 0", d); end
    rd(B + 32'h14, d); ncmp++; if (d !== 32'd0) begin nbad++; $display("FAIL mid_rst_stat got %h want 0", d); end
    rd(B + 32'h0C, d); ncmp++; if (d !== 32'hFFFF_FFFF) begin nbad++; $display("FAIL mid_rst_cmp got %h want ffffffff", d); end
    rd(B + 32'h04, d); ncmp++; if (d !== 32'd0) begin nbad++; $display("FAIL mid_rst_sw got %h want 0", d); end
    repeat (2) @(negedge clk);
    rd(B + 32'h08, d); ncmp++; if (d !== 32'd0) begin nbad++; $display("FAIL post_rst_idle got %h want 0", d); end
  endtask

  initial begin
    @(negedge clk);
    test_reset();
    test_led();
    test_switch();
    test_timer_auto();
    test_oneshot();
    test_wrap();
    test_collision();
    test_reset_midcount();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nbad);
    $finish;
  end

endmodule
